// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer: full-throughput
// valid/ready handshake whose upstream ready never depends on downstream ready.
module pipe_stage_reg #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [1:0]         o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      head_pc_q, head_pc_d;
  logic [INSTR_W-1:0]   head_instr_q, head_instr_d;
  logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;

  logic accept;
  logic fire;

  // Ready comes from registered state only; reset gates it so nothing is
  // accepted while the stage is being cleared.
  assign o_ready = ~i_reset & (state_q != FULL);
  assign o_valid = (state_q != EMPTY);
  assign accept  = i_valid & o_ready;
  assign fire    = o_valid & i_ready;

  // Head data is held across bubbles; only the visible instruction is masked.
  assign o_pc    = head_pc_q;
  assign o_instr = o_valid ? head_instr_q : NOP_INSTR;

  always_comb begin
    o_count = 2'd0;
    case (state_q)
      EMPTY:   o_count = 2'd0;
      ONE:     o_count = 2'd1;
      FULL:    o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (i_flush) begin
      state_d      = EMPTY;
      head_instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            head_pc_d    = i_pc;
            head_instr_d = i_instr;
          end
        end
        ONE: begin
          if (accept && fire) begin
            head_pc_d    = i_pc;
            head_instr_d = i_instr;
          end else if (accept) begin
            state_d      = FULL;
            skid_pc_d    = i_pc;
            skid_instr_d = i_instr;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            state_d      = ONE;
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= EMPTY;
      head_pc_q    <= '0;
      head_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: INSTR_W, 32, instruction field width in bits.
REQ-002 Parameter: PC_W, 32, incremented-PC field width in bits.
REQ-003 Parameter: NOP_INSTR, {INSTR_W{1'b0}}, bubble instruction value driven when the stage holds no valid entry.
REQ-004 Port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: i_reset  input  1  asynchronous, active-high reset.
REQ-006 Port: i_valid  input  1  upstream entry present.
REQ-007 Port: o_ready  output  1  stage can accept an entry this cycle.
REQ-008 Port: i_pc  input  PC_W  upstream incremented PC.
REQ-009 Port: i_instr  input  INSTR_W  upstream instruction.
REQ-010 Port: i_flush  input  1  synchronous discard of all held entries.
REQ-011 Port: o_valid  output  1  downstream entry present.
REQ-012 Port: i_ready  input  1  downstream accepts the entry this cycle.
REQ-013 Port: o_pc  output  PC_W  incremented PC of the head entry.
REQ-014 Port: o_instr  output  INSTR_W  instruction of the head entry.
REQ-015 Port: o_count  output  2  number of held entries (0..2).

Function
REQ-016 Accept = i_valid & o_ready; fire = o_valid & i_ready; both are evaluated at the same rising edge.
REQ-017 Storage: one head register (drives outputs) plus one skid register; three states EMPTY (0), ONE (head only), FULL (head+skid).
REQ-018 o_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and driven from registered state only (no combinational path from i_ready).
REQ-019 EMPTY: accept -> ONE, input loaded into head; no accept -> stay EMPTY.
REQ-020 ONE: accept & fire -> ONE, head loaded with input; accept & !fire -> FULL, input loaded into skid; !accept & fire -> EMPTY; neither -> hold.
REQ-021 FULL: fire -> ONE, skid moved into head; !fire -> hold, head and skid unchanged.
REQ-022 Latency SHALL be one cycle: an entry accepted at edge N appears on o_valid/o_pc/o_instr after edge N when the stage was EMPTY.
REQ-023 Entries SHALL leave in acceptance order; none is duplicated or dropped except by flush.
REQ-024 o_valid SHALL be 1 exactly in ONE and FULL; o_count SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-025 While o_valid=0, o_instr SHALL equal NOP_INSTR and o_pc SHALL hold its last value.
REQ-026 Flush: at an edge with i_flush=1, the next state SHALL be EMPTY, head instruction SHALL be set to NOP_INSTR, and any simultaneous accept SHALL be discarded.
REQ-027 Flush SHALL take priority over accept and fire; a fire in the same cycle still counts as delivered downstream.
REQ-028 Head and skid data SHALL change only on load or move; a held entry SHALL stay stable while i_ready=0.
REQ-029 i_pc/i_instr SHALL be ignored when accept=0.

Reset
REQ-030 Asserting i_reset SHALL immediately (without a clock edge) force EMPTY, o_valid=0, o_count=0, o_instr=NOP_INSTR, o_pc=0, and skid contents to zero.
REQ-031 While i_reset=1, o_ready SHALL be 0; after deassertion the first edge SHALL see o_ready=1.
REQ-032 Reset asserted mid-operation (ONE or FULL) SHALL discard all held entries.

Verification
REQ-033 Empty pass-through: i_ready=1, accept pc=0x4 instr=0x20080005 at edge 1 -> after edge 1 o_valid=1, o_pc=0x4, o_instr=0x20080005, o_count=1.
REQ-034 Stall fill: i_ready=0, accept A(pc 0x4) then B(pc 0x8) -> o_count=2, o_ready=0, o_pc=0x4; raise i_ready -> A then B delivered on consecutive edges, o_count 2->1->0.
REQ-035 Back-to-back streaming: i_valid=i_ready=1 for 8 cycles with pc 0x4..0x20 -> outputs 0x4..0x20 in order, o_count stays 1, o_ready stays 1.
REQ-036 Flush in FULL with simultaneous i_valid=1 (pc 0xC) -> next cycle o_valid=0, o_count=0, o_instr=NOP_INSTR; 0xC never appears on o_pc with o_valid=1.
REQ-037 Async reset between edges while FULL -> o_valid=0, o_count=0, o_ready=0, o_instr=NOP_INSTR immediately, before the next i_clk edge.
REQ-038 Parameter sweep INSTR_W=16, PC_W=12, NOP_INSTR=16'hFFFF -> REQ-033..037 pass; idle o_instr=16'hFFFF.
